sprite_tile_renderer: RTL and testbench
=======================================

# sprite_tile_renderer

Parametrised palettized sprite renderer for the VGA pixel pipeline. It places a W×H indexed-colour image at a runtime position with power-of-two integer scaling, and fetches pixel indices from an external synchronous ROM. Indices resolve through a runtime-loadable palette register file. The block emits registered RGB444 plus an opaque flag, so a downstream compositor can layer several sprites (pads, playhead, labels) over the background.

## Interface
Parameters:
- IMG_W, 35, sprite width in source pixels
- IMG_H, 35, sprite height in source pixels
- BPP, 1, bits per pixel index; palette depth 2^BPP
- SCALE_LOG2, 0, display scale = 2^SCALE_LOG2 per axis
- TRANSP_IDX, 0, index treated as transparent
- BLINK_FRAMES, 30, frames per highlight blink half-period

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  high = active display region
- pos_x  in  10  sprite top-left column
- pos_y  in  10  sprite top-left row
- hilite  in  1  request blinking highlight
- rom_addr  out  clog2(IMG_W*IMG_H)  registered ROM address
- rom_q  in  BPP  ROM data, valid 1 cycle after rom_addr
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry to write
- pal_rgb  in  12  {r,g,b} value to write
- red, green, blue  out  4 each  registered pixel colour
- opaque  out  1  registered: pixel belongs to sprite and is non-transparent

## Operation
- Hit test: hit = blank & DrawX∈[pos_x, pos_x+IMG_W<<SCALE_LOG2) & DrawY∈[pos_y, pos_y+IMG_H<<SCALE_LOG2). Compute the differences at 11 bits. Sums above 1023 clip naturally: no wrap onto column 0.
- col = (DrawX−pos_x)>>SCALE_LOG2; row = (DrawY−pos_y)>>SCALE_LOG2; addr = row*IMG_W + col, using a constant multiply with no divider. When hit=0, rom_addr holds 0.
- Palette: 2^BPP×12-bit register file. It is written at posedge when pal_we=1, and read combinationally in stage 2. A write to an index being read that same cycle returns the old value.
- Transparency: rom_q==TRANSP_IDX, or a stage-2 hit of 0, forces opaque=0 and rgb=0.
- Blink: frame_cnt increments on each edge where DrawX==0 && DrawY==0. When it reaches BLINK_FRAMES−1 it clears and phase toggles. frame_cnt and phase clear whenever hilite=0.
- Position inputs are sampled only in stage 0. A mid-frame change takes effect on the next pixel; there is no shadowing.
- Reset (async assert, sync release): every output is 0, including rom_addr and opaque. Pipeline valid bits, frame_cnt, phase and all palette entries are 0. Reset mid-line drops in-flight pixels.

## Timing
- Stage 0, edge N: hit_q and rom_addr are registered from the DrawX/DrawY/blank values sampled at N.
- Stage 1, edge N+1: the ROM registers rom_q; hit is delayed one stage.
- Stage 2, edge N+2: palette lookup, transparency/highlight applied, then red/green/blue/opaque are registered.
- Latency is 2 cycles. Throughput is one pixel per clock, with no stalls.
- The caller offsets DrawX by 2 or accepts a 2-pixel shift; this is documented, not compensated internally.

## Configuration
- SPRITE_HILITE_EN defined: blink logic is present. While hilite=1 and phase=1, output rgb = ~palette rgb on opaque pixels. opaque itself is unaffected.
- Undefined: frame_cnt and phase are removed and hilite is ignored. Output is always the palette colour.

## Structure
- Package sprite_pkg holds rgb444_t (a packed struct of three 4-bit fields), the addr_w(W,H) clog2 helper constant function and the pixel pipeline latency constant SPRITE_LAT=2.
- Sub-module sprite_palette_rf: a parametrised BPP-indexed register file with an async-reset write port and combinational read.
- Top level: hit/address stage, delay registers, output stage, optional blink counter.

## Test plan
- Identity: IMG 35×35, SCALE_LOG2=0, pos (0,0), ROM pattern addr[0] → DrawX=5,DrawY=2 gives rom_addr=75, and after 2 cycles red/green/blue equal the palette entry of rom_q.
- Scaling: SCALE_LOG2=2, pos (100,40) → DrawX=107,DrawY=45 gives rom_addr=36. DrawX=240 is a miss: opaque=0, rgb=0.
- Transparency: TRANSP_IDX=0, rom_q=0 inside the sprite → opaque=0, rgb=0. rom_q=1 with palette[1]=12'hF80 → opaque=1, rgb F/8/0.
- Palette write: pal_we with idx 1 = 12'h0F0 during streaming → pixels using index 1 change from the next stage-2 edge. A same-cycle read sees the old value.
- Blink (SPRITE_HILITE_EN, BLINK_FRAMES=2): hilite=1 over 4 simulated frames → opaque pixels alternate normal/inverted every 2 frames. Deasserting hilite returns normal colour immediately.
- Reset: assert reset_n=0 mid-line with output non-zero → all outputs 0 asynchronously. After release, first valid pixel appears 2 cycles after the first hit.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite renderer
// Purpose: RGB444 pixel struct, ROM address width helper, pipeline latency.
// Ports: none (package).
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Cycles from DrawX/DrawY sample edge to registered colour output.
  localparam int SPRITE_LAT = 2;

  // ROM address width for a w x h image; never narrower than one bit.
  function automatic int addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/sprite_tile_renderer_if.sv
// rtl/sprite_tile_renderer_if.sv - ROM fetch and palette write bus of the sprite renderer
// Purpose: groups the external sync-ROM port and the palette write port.
// Signals: rom_addr (renderer -> ROM), rom_q (ROM -> renderer, 1 cycle after addr),
//          pal_we/pal_idx/pal_rgb (host -> renderer palette write).
// Modports: master = renderer side, slave = ROM/host side.
interface sprite_tile_renderer_if
  import sprite_pkg::*;
#(
  parameter int BPP = 1,
  parameter int AW  = 11
) ();

  logic [AW-1:0]  rom_addr;
  logic [BPP-1:0] rom_q;
  logic           pal_we;
  logic [BPP-1:0] pal_idx;
  rgb444_t        pal_rgb;

  modport master (
    output rom_addr,
    input  rom_q,
    input  pal_we,
    input  pal_idx,
    input  pal_rgb
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    output pal_we,
    output pal_idx,
    output pal_rgb
  );

endinterface

// File: rtl/sprite_palette_rf.sv
// rtl/sprite_palette_rf.sv - 2^BPP x 12-bit palette register file
// Purpose: one write port (posedge, async active-low reset to 0), one
//          combinational read port. A read of an entry written on the same
//          edge sees the old value.
// Ports: clk, rst_n, we/widx/wdata (write), ridx/rdata (read).
module sprite_palette_rf
  import sprite_pkg::*;
#(
  parameter int BPP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [BPP-1:0] widx,
  input  rgb444_t        wdata,
  input  logic [BPP-1:0] ridx,
  output rgb444_t        rdata
);

  localparam int DEPTH = 1 << BPP;

  rgb444_t mem_q [DEPTH];
  rgb444_t mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[widx] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/sprite_tile_renderer.sv
// rtl/sprite_tile_renderer.sv - palettized sprite renderer, 2-cycle pixel pipeline
// Purpose: hit-tests DrawX/DrawY against a scaled IMG_W x IMG_H sprite at
//          (pos_x,pos_y), fetches the pixel index from an external sync ROM,
//          resolves it through a palette and registers RGB444 + opaque.
// Ports: vga_clk, reset_n (async active-low); DrawX/DrawY/blank video timing;
//        pos_x/pos_y placement; hilite blink request; bus (ROM + palette
//        write, master modport); red/green/blue/opaque registered outputs.
// Optional: SPRITE_HILITE_EN adds the frame blink counter; hilite then
//           inverts opaque pixel colour on alternate blink half-periods.
module sprite_tile_renderer
  import sprite_pkg::*;
#(
  parameter int IMG_W        = 35,
  parameter int IMG_H        = 35,
  parameter int BPP          = 1,
  parameter int SCALE_LOG2   = 0,
  parameter int TRANSP_IDX   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  hilite,
  sprite_tile_renderer_if.master bus,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic                  opaque
);

  localparam int AW     = addr_w(IMG_W, IMG_H);
  localparam int SPAN_W = IMG_W << SCALE_LOG2;
  localparam int SPAN_H = IMG_H << SCALE_LOG2;

  logic [10:0]   dx, dy;
  logic [9:0]    col, row;
  logic          hit0_q, hit0_d;
  logic          hit1_q, hit1_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  rgb444_t       rgb_q, rgb_d;
  logic          opaque_q, opaque_d;
  rgb444_t       pal_rd;
  logic          invert;

  sprite_palette_rf #(.BPP(BPP)) u_pal (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .we    (bus.pal_we),
    .widx  (bus.pal_idx),
    .wdata (bus.pal_rgb),
    .ridx  (bus.rom_q),
    .rdata (pal_rd)
  );

  // Stage 0: 11-bit differences; bit 10 set means DrawX/DrawY lies left of /
  // above the sprite, so the window never wraps round to column/row 0.
  always_comb begin
    dx         = {1'b0, DrawX} - {1'b0, pos_x};
    dy         = {1'b0, DrawY} - {1'b0, pos_y};
    col        = dx[9:0] >> SCALE_LOG2;
    row        = dy[9:0] >> SCALE_LOG2;
    hit0_d     = blank
               && !dx[10] && (32'(dx[9:0]) < SPAN_W)
               && !dy[10] && (32'(dy[9:0]) < SPAN_H);
    rom_addr_d = hit0_d ? AW'(AW'(row) * AW'(IMG_W) + AW'(col)) : '0;
    hit1_d     = hit0_q;
  end

`ifdef SPRITE_HILITE_EN
  localparam int FCW = $clog2(BLINK_FRAMES + 1);

  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (!hilite) begin
      frame_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (DrawX == 10'd0 && DrawY == 10'd0) begin
      if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // hilite gates directly so dropping it restores normal colour at once.
  assign invert = hilite & phase_q;
`else
  logic unused_hilite;
  assign unused_hilite = hilite & (BLINK_FRAMES > 0);
  assign invert        = 1'b0;
`endif

  // Stage 2: rom_q is the index fetched for the pixel whose hit is in hit1_q.
  always_comb begin
    opaque_d = hit1_q && (bus.rom_q != BPP'(TRANSP_IDX));
    rgb_d    = '0;
    if (opaque_d) begin
      rgb_d = invert ? rgb444_t'(~pal_rd) : pal_rd;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit0_q     <= 1'b0;
      hit1_q     <= 1'b0;
      rom_addr_q <= '0;
      rgb_q      <= '0;
      opaque_q   <= 1'b0;
    end else begin
      hit0_q     <= hit0_d;
      hit1_q     <= hit1_d;
      rom_addr_q <= rom_addr_d;
      rgb_q      <= rgb_d;
      opaque_q   <= opaque_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign red          = rgb_q.r;
  assign green        = rgb_q.g;
  assign blue         = rgb_q.b;
  assign opaque       = opaque_q;

endmodule

// File: tb/tb_sprite_tile_renderer.sv
// tb/tb_sprite_tile_renderer.sv - directed self-checking bench for sprite_tile_renderer
// Purpose: two instances (scale 1 and scale 4) sharing video timing, each with
//          its own sync ROM model returning rom_addr[0].
module tb_sprite_tile_renderer;
  import sprite_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, hilite;
  logic [3:0] red0, green0, blue0, red1, green1, blue1;
  logic       opaque0, opaque1;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_tile_renderer_if #(.BPP(1), .AW(11)) bus0 ();
  sprite_tile_renderer_if #(.BPP(1), .AW(11)) bus1 ();

  sprite_tile_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) u_dut0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .hilite(hilite), .bus(bus0),
    .red(red0), .green(green0), .blue(blue0), .opaque(opaque0)
  );

  sprite_tile_renderer #(.SCALE_LOG2(2), .BLINK_FRAMES(2)) u_dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .hilite(hilite), .bus(bus1),
    .red(red1), .green(green1), .blue(blue1), .opaque(opaque1)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    bus0.rom_q <= bus0.rom_addr[0];
    bus1.rom_q <= bus1.rom_addr[0];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic pal_write(input logic idx, input logic [11:0] rgb);
    bus0.pal_we = 1'b1; bus0.pal_idx = idx; bus0.pal_rgb = rgb;
    bus1.pal_we = 1'b1; bus1.pal_idx = idx; bus1.pal_rgb = rgb;
    step();
    bus0.pal_we = 1'b0;
    bus1.pal_we = 1'b0;
  endtask

  // One pixel through both pipelines: addresses captured after stage 0,
  // outputs valid on return.
  task automatic render(input int x, input int y, input logic b,
                        output logic [10:0] a0, output logic [10:0] a1);
    pix(x, y, b);
    step();
    a0 = bus0.rom_addr;
    a1 = bus1.rom_addr;
    blank = 1'b0;
    step();
    step();
  endtask

  logic [10:0] a0, a1;
  logic [12:0] exp_px;
  int          m;

  initial begin
    reset_n = 1'b0; hilite = 1'b0; pos_x = '0; pos_y = '0;
    pix(0, 0, 1'b0);
    bus0.pal_we = 1'b0; bus0.pal_idx = '0; bus0.pal_rgb = '0;
    bus1.pal_we = 1'b0; bus1.pal_idx = '0; bus1.pal_rgb = '0;
    repeat (3) step();

    check("reset_out0",  {opaque0, red0, green0, blue0}, 13'h0);
    check("reset_out1",  {opaque1, red1, green1, blue1}, 13'h0);
    check("reset_addr0", bus0.rom_addr, 11'd0);
    check("reset_addr1", bus1.rom_addr, 11'd0);

    reset_n = 1'b1;
    step();
    pal_write(1'b1, 12'hF80);
    pal_write(1'b0, 12'h0AB);

    // Identity placement at (0,0)
    render(5, 2, 1'b1, a0, a1);
    check("ident_addr", a0, 11'd75);
    check("ident_px",   {opaque0, red0, green0, blue0}, 13'h1F80);
    render(4, 2, 1'b1, a0, a1);
    check("transp_addr", a0, 11'd74);
    check("transp_px",   {opaque0, red0, green0, blue0}, 13'h0);
    render(35, 2, 1'b1, a0, a1);
    check("miss_right_addr", a0, 11'd0);
    check("miss_right_px",   {opaque0, red0, green0, blue0}, 13'h0);
    render(34, 1, 1'b1, a0, a1);
    check("last_col_addr", a0, 11'd69);
    check("last_col_px",   {opaque0, red0, green0, blue0}, 13'h1F80);
    render(5, 2, 1'b0, a0, a1);
    check("blank_addr", a0, 11'd0);
    check("blank_px",   {opaque0, red0, green0, blue0}, 13'h0);

    // Sprite near the right edge must not wrap onto column 0
    pos_x = 10'd1000;
    render(3, 0, 1'b1, a0, a1);
    check("nowrap_addr", a0, 11'd0);
    check("nowrap_px",   {opaque0, red0, green0, blue0}, 13'h0);
    render(1021, 0, 1'b1, a0, a1);
    check("edge_addr", a0, 11'd21);
    check("edge_px",   {opaque0, red0, green0, blue0}, 13'h1F80);

    // Scale x4 at (100,40)
    pos_x = 10'd100; pos_y = 10'd40;
    render(107, 45, 1'b1, a0, a1);
    check("scale_addr36", a1, 11'd36);
    check("scale_px36",   {opaque1, red1, green1, blue1}, 13'h0);
    render(111, 45, 1'b1, a0, a1);
    check("scale_addr37", a1, 11'd37);
    check("scale_px37",   {opaque1, red1, green1, blue1}, 13'h1F80);
    render(240, 45, 1'b1, a0, a1);
    check("scale_miss_addr", a1, 11'd0);
    check("scale_miss_px",   {opaque1, red1, green1, blue1}, 13'h0);
    render(239, 45, 1'b1, a0, a1);
    check("scale_lastx_addr", a1, 11'd69);
    check("scale_lastx_px",   {opaque1, red1, green1, blue1}, 13'h1F80);
    render(107, 179, 1'b1, a0, a1);
    check("scale_lasty_addr", a1, 11'd1191);
    render(107, 180, 1'b1, a0, a1);
    check("scale_missy_addr", a1, 11'd0);
    check("scale_missy_px",   {opaque1, red1, green1, blue1}, 13'h0);

    // Palette write while streaming pixel (5,2)
    pos_x = '0; pos_y = '0;
    pix(5, 2, 1'b1);
    repeat (3) step();
    check("stream_px", {opaque0, red0, green0, blue0}, 13'h1F80);
    bus0.pal_we = 1'b1; bus0.pal_idx = 1'b1; bus0.pal_rgb = 12'h0F0;
    bus1.pal_we = 1'b1; bus1.pal_idx = 1'b1; bus1.pal_rgb = 12'h0F0;
    step();
    bus0.pal_we = 1'b0;
    bus1.pal_we = 1'b0;
    check("pal_same_cycle", {opaque0, red0, green0, blue0}, 13'h1F80);
    step();
    check("pal_next_edge", {opaque0, red0, green0, blue0}, 13'h10F0);

    // Asynchronous reset mid-line
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_px",   {opaque0, red0, green0, blue0}, 13'h0);
    check("async_rst_addr", bus0.rom_addr, 11'd0);
    blank = 1'b0;
    step();
    reset_n = 1'b1;
    pix(5, 2, 1'b1);
    step();
    check("post_rst_addr", bus0.rom_addr, 11'd75);
    check("post_rst_op_n", opaque0, 1'b0);
    blank = 1'b0;
    step();
    check("post_rst_op_n1", opaque0, 1'b0);
    step();
    check("post_rst_op_n2", {opaque0, red0, green0, blue0}, 13'h1000);

    // Blink: frame markers at (0,0) interleaved with a test pixel
    pal_write(1'b1, 12'hF80);
    hilite = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pix(0, 0, 1'b1);
      step();
      render(5, 2, 1'b1, a0, a1);
      m = f + 1;
`ifdef SPRITE_HILITE_EN
      exp_px = (((m / 2) % 2) == 1) ? 13'h107F : 13'h1F80;
`else
      exp_px = 13'h1F80;
`endif
      check($sformatf("blink_f%0d", f), {opaque0, red0, green0, blue0}, {19'd0, exp_px});
    end
    hilite = 1'b0;
    render(5, 2, 1'b1, a0, a1);
    check("hilite_off", {opaque0, red0, green0, blue0}, 13'h1F80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
